enigma_display_scanner: RTL and testbench



---
 rtl/enigma_display_scanner_pkg.sv | 30 +++
 rtl/enigma_display_scanner_if.sv | 55 +++++
 rtl/enigma_display_scanner_seg.sv | 48 ++++
 rtl/enigma_display_scanner.sv | 149 ++++++++++++++
 tb/tb_enigma_display_scanner.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/enigma_display_scanner_pkg.sv
// Shared types and constants for the Enigma 4-digit display scanner.
// Digit map: 0 = output letter, 1..3 = rotor r0..r2 positions.
package enigma_disp_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int CODE_W     = 6;
   localparam int LETTER_MAX = 25;

   typedef logic [CODE_W-1:0] code_t;
   typedef logic [6:0]        seg_t;
   typedef logic [1:0]        dig_t;
   typedef code_t [NUM_DIGITS-1:0] codes_t;

   localparam code_t BLANK_CODE = 6'd63;
   localparam seg_t  SEG_BLANK  = 7'h7F;

   localparam dig_t DIG_LETTER = 2'd0;
   localparam dig_t DIG_R0     = 2'd1;
   localparam dig_t DIG_R1     = 2'd2;
   localparam dig_t DIG_R2     = 2'd3;

   function automatic logic is_letter(input code_t c);
      return c <= code_t'(LETTER_MAX);
   endfunction

   function automatic logic [NUM_DIGITS-1:0] anode_on(input dig_t d);
      return ~(4'b0001 << d);
   endfunction

endpackage

// File: rtl/enigma_display_scanner_if.sv
// Load/digit bus between Enigma core and display scanner.
// SEG_BLINK_EN adds the rotor-edit blink controls.
interface enigma_display_scanner_if;
   import enigma_disp_pkg::*;

   logic       load;
   code_t      letter_in;
   code_t      r0_pos;
   code_t      r1_pos;
   code_t      r2_pos;
   logic [3:0] digit_en;
   logic [3:0] an;
   seg_t       seg;
   logic       frame_tick;
   logic       pending;
`ifdef SEG_BLINK_EN
   logic       edit_active;
   logic [1:0] edit_sel;
`endif

   modport master (
`ifdef SEG_BLINK_EN
      output edit_active,
      output edit_sel,
`endif
      output load,
      output letter_in,
      output r0_pos,
      output r1_pos,
      output r2_pos,
      output digit_en,
      input  an,
      input  seg,
      input  frame_tick,
      input  pending
   );

   modport slave (
`ifdef SEG_BLINK_EN
      input  edit_active,
      input  edit_sel,
`endif
      input  load,
      input  letter_in,
      input  r0_pos,
      input  r1_pos,
      input  r2_pos,
      input  digit_en,
      output an,
      output seg,
      output frame_tick,
      output pending
   );

endinterface

// File: rtl/enigma_display_scanner_seg.sv
// seg_letter_display: letter code 0..25 to active-low segments {g,f,e,d,c,b,a}.
// Out-of-range codes decode to all segments off.
module seg_letter_display
   import enigma_disp_pkg::*;
(
   input  code_t code_i,
   output seg_t  seg_o
);

   seg_t lit;

   // Table is active-high (lit segment = 1); inverted once at the output.
   always_comb begin
      lit = 7'h00;
      case (code_i)
         6'd0:  lit = 7'h77;
         6'd1:  lit = 7'h7C;
         6'd2:  lit = 7'h39;
         6'd3:  lit = 7'h5E;
         6'd4:  lit = 7'h79;
         6'd5:  lit = 7'h71;
         6'd6:  lit = 7'h3D;
         6'd7:  lit = 7'h76;
         6'd8:  lit = 7'h30;
         6'd9:  lit = 7'h1E;
         6'd10: lit = 7'h75;
         6'd11: lit = 7'h38;
         6'd12: lit = 7'h37;
         6'd13: lit = 7'h54;
         6'd14: lit = 7'h3F;
         6'd15: lit = 7'h73;
         6'd16: lit = 7'h67;
         6'd17: lit = 7'h50;
         6'd18: lit = 7'h6D;
         6'd19: lit = 7'h78;
         6'd20: lit = 7'h3E;
         6'd21: lit = 7'h1C;
         6'd22: lit = 7'h2A;
         6'd23: lit = 7'h64;
         6'd24: lit = 7'h6E;
         6'd25: lit = 7'h5B;
         default: lit = 7'h00;
      endcase
   end

   assign seg_o = ~lit;

endmodule

// File: rtl/enigma_display_scanner.sv
// Time-multiplexed 4-digit common-anode scanner with guard blanking.
// Optional SEG_BLINK_EN blinks the rotor digit being edited.
module enigma_display_scanner
   import enigma_disp_pkg::*;
#(
   parameter int SLOT_CYCLES  = 25000,
   parameter int GUARD_CYCLES = 16
`ifdef SEG_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 250
`endif
) (
   input  logic clk,
   input  logic rst_n,
   enigma_display_scanner_if.slave bus
);

   localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

   generate
      if (SLOT_CYCLES < 2) begin : g_bad_slot
         $error("SLOT_CYCLES must be >= 2");
      end
      if (GUARD_CYCLES >= SLOT_CYCLES) begin : g_bad_guard
         $error("GUARD_CYCLES must be < SLOT_CYCLES");
      end
   endgenerate

   logic [CNT_W-1:0] cnt_q, cnt_d;
   dig_t             idx_q, idx_d;
   codes_t           shadow_q, shadow_d;
   codes_t           active_q, active_d;
   logic             pending_q, pending_d;
   logic [3:0]       an_q, an_d;
   seg_t             seg_q, seg_d;
   logic             tick_q;

   logic   wrap;
   logic   boundary;
   logic   guard;
   logic   hide_edit;
   codes_t in_codes;
   code_t  cur_code;
   seg_t   dec_seg;

   assign wrap     = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
   assign boundary = wrap && (idx_q == DIG_R2);
   assign guard    = (cnt_q < CNT_W'(GUARD_CYCLES));
   assign cur_code = active_q[idx_q];

   assign in_codes[DIG_LETTER] = bus.letter_in;
   assign in_codes[DIG_R0]     = bus.r0_pos;
   assign in_codes[DIG_R1]     = bus.r1_pos;
   assign in_codes[DIG_R2]     = bus.r2_pos;

   seg_letter_display u_dec (
      .code_i (cur_code),
      .seg_o  (dec_seg)
   );

`ifdef SEG_BLINK_EN
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [FRM_W-1:0] frm_q;
   logic             blink_q;

   // edit_sel 0..2 selects rotor digits 1..3; 3 matches no digit.
   assign hide_edit = bus.edit_active && !blink_q &&
                      ({1'b0, idx_q} == (3'(bus.edit_sel) + 3'd1));
`else
   assign hide_edit = 1'b0;
`endif

   always_comb begin
      cnt_d     = wrap ? '0 : cnt_q + 1'b1;
      idx_d     = wrap ? idx_q + 2'd1 : idx_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (boundary) begin
         pending_d = 1'b0;
         if (bus.load) begin
            shadow_d = in_codes;
            active_d = in_codes;
         end else if (pending_q) begin
            active_d = shadow_q;
         end
      end else if (bus.load) begin
         shadow_d  = in_codes;
         pending_d = 1'b1;
      end
   end

   always_comb begin
      an_d = 4'b1111;
      priority case (1'b1)
         guard:                   an_d = 4'b1111;
         !bus.digit_en[idx_q]:    an_d = 4'b1111;
         hide_edit:               an_d = 4'b1111;
         default:                 an_d = anode_on(idx_q);
      endcase
      seg_d = SEG_BLANK;
      if (!guard && is_letter(cur_code)) begin
         seg_d = dec_seg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         idx_q     <= DIG_LETTER;
         shadow_q  <= {NUM_DIGITS{BLANK_CODE}};
         active_q  <= {NUM_DIGITS{BLANK_CODE}};
         pending_q <= 1'b0;
         an_q      <= 4'b1111;
         seg_q     <= SEG_BLANK;
         tick_q    <= 1'b0;
`ifdef SEG_BLINK_EN
         frm_q     <= '0;
         blink_q   <= 1'b1;
`endif
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         tick_q    <= boundary;
`ifdef SEG_BLINK_EN
         if (boundary) begin
            if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
               frm_q   <= '0;
               blink_q <= ~blink_q;
            end else begin
               frm_q <= frm_q + 1'b1;
            end
         end
`endif
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.frame_tick = tick_q;
   assign bus.pending    = pending_q;

endmodule

// File: tb/tb_enigma_display_scanner.sv
// Directed bench for enigma_display_scanner (SLOT=8, GUARD=2, BLINK=2).
// Blink scenario is compiled only with SEG_BLINK_EN.
module tb_enigma_display_scanner;
   import enigma_disp_pkg::*;

   localparam int SLOT  = 8;
   localparam int GUARD = 2;
   localparam int FRAME = 4 * SLOT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   enigma_display_scanner_if bus ();

   enigma_display_scanner #(
      .SLOT_CYCLES  (SLOT),
      .GUARD_CYCLES (GUARD)
`ifdef SEG_BLINK_EN
      ,
      .BLINK_FRAMES (2)
`endif
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Hand-derived active-low patterns for the codes used below.
   function automatic seg_t dec(input code_t c);
      case (c)
         6'd0:    return 7'h08;
         6'd1:    return 7'h03;
         6'd2:    return 7'h46;
         6'd3:    return 7'h21;
         6'd4:    return 7'h06;
         6'd7:    return 7'h09;
         default: return 7'h7F;
      endcase
   endfunction

   // kk = state index within a frame whose outputs are visible now.
   function automatic logic [3:0] exp_an(input int kk, input logic [3:0] en);
      int d;
      d = kk / SLOT;
      if ((kk % SLOT) < GUARD) return 4'b1111;
      if (!en[d]) return 4'b1111;
      return ~(4'b0001 << d);
   endfunction

   function automatic seg_t exp_seg(input int kk, input logic [23:0] codes);
      int d;
      d = kk / SLOT;
      if ((kk % SLOT) < GUARD) return 7'h7F;
      return dec(codes[6*d +: 6]);
   endfunction

   task automatic wait_tick(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4 * FRAME; i++) begin
         @(negedge clk);
         if (bus.frame_tick === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic set_codes(input code_t l, a, b, c);
      bus.letter_in = l;
      bus.r0_pos    = a;
      bus.r1_pos    = b;
      bus.r2_pos    = c;
   endtask

   task automatic test_reset;
      logic [23:0] blank;
      blank = {4{6'd63}};
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      n_chk += 4;
      if (bus.an !== 4'b1111) begin
         $display("FAIL rst_an got %b want 1111", bus.an); n_fail++;
      end
      if (bus.seg !== 7'h7F) begin
         $display("FAIL rst_seg got %h want 7f", bus.seg); n_fail++;
      end
      if (bus.frame_tick !== 1'b0) begin
         $display("FAIL rst_tick got %b want 0", bus.frame_tick); n_fail++;
      end
      if (bus.pending !== 1'b0) begin
         $display("FAIL rst_pending got %b want 0", bus.pending); n_fail++;
      end
      rst_n = 1'b1;
      for (int k = 1; k <= SLOT; k++) begin
         @(negedge clk);
         n_chk += 2;
         if (bus.an !== exp_an(k - 1, 4'b1111)) begin
            $display("FAIL rst_slot0_an k=%0d got %b want %b",
                     k, bus.an, exp_an(k - 1, 4'b1111));
            n_fail++;
         end
         if (bus.seg !== exp_seg(k - 1, blank)) begin
            $display("FAIL rst_slot0_seg k=%0d got %h want 7f", k, bus.seg);
            n_fail++;
         end
      end
   endtask

   task automatic test_load_all;
      bit ok;
      logic [23:0] codes;
      codes = {6'd3, 6'd2, 6'd1, 6'd0};
      set_codes(6'd0, 6'd1, 6'd2, 6'd3);
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      n_chk++;
      if (bus.pending !== 1'b1) begin
         $display("FAIL load_pending got %b want 1", bus.pending); n_fail++;
      end
      wait_tick(ok);
      n_chk += 2;
      if (!ok) begin
         $display("FAIL load_tick_timeout got 0 want 1"); n_fail++;
      end
      if (bus.pending !== 1'b0) begin
         $display("FAIL load_pending_clr got %b want 0", bus.pending); n_fail++;
      end
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clk);
         n_chk += 2;
         if (bus.an !== exp_an(k - 1, 4'b1111)) begin
            $display("FAIL scan_an k=%0d got %b want %b",
                     k, bus.an, exp_an(k - 1, 4'b1111));
            n_fail++;
         end
         if (bus.seg !== exp_seg(k - 1, codes)) begin
            $display("FAIL scan_seg k=%0d got %h want %h",
                     k, bus.seg, exp_seg(k - 1, codes));
            n_fail++;
         end
      end
   endtask

   task automatic test_pending_idx1;
      logic [23:0] codes;
      codes = {6'd3, 6'd2, 6'd1, 6'd0};
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clk);
         bus.load = 1'b0;
         n_chk += 2;
         if (bus.an !== exp_an(k - 1, 4'b1111)) begin
            $display("FAIL pend_an k=%0d got %b want %b",
                     k, bus.an, exp_an(k - 1, 4'b1111));
            n_fail++;
         end
         if (bus.seg !== exp_seg(k - 1, codes)) begin
            $display("FAIL pend_seg k=%0d got %h want %h",
                     k, bus.seg, exp_seg(k - 1, codes));
            n_fail++;
         end
         if (k == 10) begin
            bus.letter_in = 6'd4;
            bus.load = 1'b1;
         end
         if (k == 11) begin
            n_chk++;
            if (bus.pending !== 1'b1) begin
               $display("FAIL pend_rise got %b want 1", bus.pending); n_fail++;
            end
         end
         if (k == FRAME) begin
            n_chk += 2;
            if (bus.frame_tick !== 1'b1) begin
               $display("FAIL pend_tick got %b want 1", bus.frame_tick); n_fail++;
            end
            if (bus.pending !== 1'b0) begin
               $display("FAIL pend_clr got %b want 0", bus.pending); n_fail++;
            end
         end
      end
   endtask

   task automatic test_boundary_load;
      logic [23:0] codes;
      codes = {6'd3, 6'd2, 6'd1, 6'd4};
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clk);
         bus.load = 1'b0;
         n_chk += 3;
         if (bus.an !== exp_an(k - 1, 4'b1111)) begin
            $display("FAIL bnd_an k=%0d got %b want %b",
                     k, bus.an, exp_an(k - 1, 4'b1111));
            n_fail++;
         end
         if (bus.seg !== exp_seg(k - 1, codes)) begin
            $display("FAIL bnd_seg k=%0d got %h want %h",
                     k, bus.seg, exp_seg(k - 1, codes));
            n_fail++;
         end
         if (bus.pending !== 1'b0) begin
            $display("FAIL bnd_pending k=%0d got %b want 0", k, bus.pending);
            n_fail++;
         end
         if (k == FRAME - 1) begin
            bus.letter_in = 6'd7;
            bus.load = 1'b1;
         end
      end
      codes = {6'd3, 6'd2, 6'd1, 6'd7};
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clk);
         n_chk += 3;
         if (bus.an !== exp_an(k - 1, 4'b1111)) begin
            $display("FAIL bnd2_an k=%0d got %b want %b",
                     k, bus.an, exp_an(k - 1, 4'b1111));
            n_fail++;
         end
         if (bus.seg !== exp_seg(k - 1, codes)) begin
            $display("FAIL bnd2_seg k=%0d got %h want %h",
                     k, bus.seg, exp_seg(k - 1, codes));
            n_fail++;
         end
         if (bus.pending !== 1'b0) begin
            $display("FAIL bnd2_pending k=%0d got %b want 0", k, bus.pending);
            n_fail++;
         end
      end
   endtask

   task automatic test_bad_code_en;
      logic [23:0] codes;
      logic [3:0]  en;
      en = 4'b1011;
      bus.digit_en = en;
      bus.r1_pos = 6'd30;
      bus.load = 1'b1;
      codes = {6'd3, 6'd2, 6'd1, 6'd7};
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clk);
         bus.load = 1'b0;
         n_chk += 2;
         if (bus.an !== exp_an(k - 1, en)) begin
            $display("FAIL en_an k=%0d got %b want %b",
                     k, bus.an, exp_an(k - 1, en));
            n_fail++;
         end
         if (bus.seg !== exp_seg(k - 1, codes)) begin
            $display("FAIL en_seg k=%0d got %h want %h",
                     k, bus.seg, exp_seg(k - 1, codes));
            n_fail++;
         end
      end
      codes = {6'd3, 6'd30, 6'd1, 6'd7};
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clk);
         n_chk += 2;
         if (bus.an !== exp_an(k - 1, en)) begin
            $display("FAIL bad_an k=%0d got %b want %b",
                     k, bus.an, exp_an(k - 1, en));
            n_fail++;
         end
         if (bus.seg !== exp_seg(k - 1, codes)) begin
            $display("FAIL bad_seg k=%0d got %h want %h",
                     k, bus.seg, exp_seg(k - 1, codes));
            n_fail++;
         end
      end
   endtask

   task automatic test_mid_reset;
      logic [23:0] blank;
      blank = {4{6'd63}};
      repeat (12) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_chk += 3;
      if (bus.an !== 4'b1111) begin
         $display("FAIL mrst_an got %b want 1111", bus.an); n_fail++;
      end
      if (bus.seg !== 7'h7F) begin
         $display("FAIL mrst_seg got %h want 7f", bus.seg); n_fail++;
      end
      if (bus.frame_tick !== 1'b0) begin
         $display("FAIL mrst_tick got %b want 0", bus.frame_tick); n_fail++;
      end
      rst_n = 1'b1;
      bus.digit_en = 4'b1111;
      for (int k = 1; k <= SLOT; k++) begin
         @(negedge clk);
         n_chk += 2;
         if (bus.an !== exp_an(k - 1, 4'b1111)) begin
            $display("FAIL mrst_slot0_an k=%0d got %b want %b",
                     k, bus.an, exp_an(k - 1, 4'b1111));
            n_fail++;
         end
         if (bus.seg !== exp_seg(k - 1, blank)) begin
            $display("FAIL mrst_slot0_seg k=%0d got %h want 7f", k, bus.seg);
            n_fail++;
         end
      end
   endtask

`ifdef SEG_BLINK_EN
   task automatic test_blink;
      int f, kk;
      logic [3:0] want;
      rst_n = 1'b0;
      bus.edit_active = 1'b1;
      bus.edit_sel = 2'd1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 6 * FRAME; k++) begin
         @(negedge clk);
         f  = (k - 1) / FRAME;
         kk = (k - 1) % FRAME;
         if ((kk / SLOT) == 2 && (kk % SLOT) >= GUARD) begin
            want = (((f / 2) % 2) == 0) ? 4'b1011 : 4'b1111;
            n_chk++;
            if (bus.an !== want) begin
               $display("FAIL blink_an f=%0d k=%0d got %b want %b",
                        f, kk, bus.an, want);
               n_fail++;
            end
         end
      end
      bus.edit_active = 1'b0;
   endtask
`endif

   initial begin
      bus.load = 1'b0;
      bus.digit_en = 4'b1111;
      set_codes(6'd0, 6'd0, 6'd0, 6'd0);
`ifdef SEG_BLINK_EN
      bus.edit_active = 1'b0;
      bus.edit_sel = 2'd3;
`endif
      test_reset();
      test_load_all();
      test_pending_idx1();
      test_boundary_load();
      test_bad_code_en();
      test_mid_reset();
`ifdef SEG_BLINK_EN
      test_blink();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
